// File: rtl/branch_verify_queue_pkg.sv
// ----------------------------------------------------------------------------
// branch_verify_queue_pkg
//   Shared types and constants for the branch verification queue.
//   - bvq_entry_t  : one in-flight prediction {addr, pred_taken, pred_addr}
//   - BVQ_FALLTHRU : distance from a branch PC to its not-taken successor,
//                    which skips the architectural delay slot.
// ----------------------------------------------------------------------------
package branch_verify_queue_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        pred_taken;
    logic [31:0] pred_addr;
  } bvq_entry_t;

  localparam logic [31:0] BVQ_FALLTHRU = 32'd8;

endpackage : branch_verify_queue_pkg

// File: rtl/branch_verify_queue_if.sv
// ----------------------------------------------------------------------------
// branch_verify_queue_if
//   Bundles the fetch-side prediction inputs, the MEM-side resolution inputs
//   and the flush/redirect/statistics outputs of branch_verify_queue.
//   master : the pipeline side (drives fetch/resolve, observes results)
//   slave  : the queue itself
// ----------------------------------------------------------------------------
interface branch_verify_queue_if #(
  parameter int CNT_W = 32
) ();

  // Fetch side
  logic             Fetch_valid;
  logic             Fetch_is_branch;
  logic [31:0]      Fetch_addr;
  logic             Pred_taken;
  logic [31:0]      Pred_addr;
  // MEM side
  logic             Resolve_valid;
  logic [31:0]      Resolve_addr;
  logic             Resolve_taken;
  logic [31:0]      Resolve_target;
  // Results
  logic             Full;
  logic             Flush_out;
  logic [31:0]      Redirect_addr;
  logic [CNT_W-1:0] Branch_count;
  logic [CNT_W-1:0] Mispredict_count;

  modport master (
    output Fetch_valid, Fetch_is_branch, Fetch_addr, Pred_taken, Pred_addr,
    output Resolve_valid, Resolve_addr, Resolve_taken, Resolve_target,
    input  Full, Flush_out, Redirect_addr, Branch_count, Mispredict_count
  );

  modport slave (
    input  Fetch_valid, Fetch_is_branch, Fetch_addr, Pred_taken, Pred_addr,
    input  Resolve_valid, Resolve_addr, Resolve_taken, Resolve_target,
    output Full, Flush_out, Redirect_addr, Branch_count, Mispredict_count
  );

endinterface : branch_verify_queue_if

// File: rtl/branch_verify_queue_pred_fifo.sv
// ----------------------------------------------------------------------------
// pred_fifo
//   Circular buffer of in-flight predictions.
//   Ports:
//     CLK, RESET   clock, asynchronous active-low reset
//     push_i       write wr_entry_i at the tail (ignored when full)
//     pop_i        drop the head entry (ignored when empty)
//     clear_i      discard every entry; overrides push and pop
//     wr_entry_i   entry to write
//     head_o       oldest entry (meaningless while empty_o=1)
//     full_o       DEPTH entries held
//     empty_o      no entries held
// ----------------------------------------------------------------------------
module pred_fifo
  import branch_verify_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       clear_i,
  input  bvq_entry_t wr_entry_i,
  output bvq_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  bvq_entry_t       mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A clear discards the whole queue, so neither the push nor the pop of
  // that cycle may touch the storage or pointers.
  assign do_push = push_i & ~full_o  & ~clear_i;
  assign do_pop  = pop_i  & ~empty_o & ~clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_entry_i;
  end

endmodule : pred_fifo

// File: rtl/branch_verify_queue.sv
// ----------------------------------------------------------------------------
// branch_verify_queue
//   Records each predicted branch at fetch and checks it when MEM resolves
//   the branch. On a misprediction it pulses Flush_out for one cycle with the
//   correct next fetch PC on Redirect_addr, and discards all queued (now
//   wrong-path) predictions.
//   Ports:
//     CLK    clock
//     RESET  asynchronous, active-low reset
//     bus    branch_verify_queue_if.slave:
//            Fetch_valid/Fetch_is_branch/Fetch_addr/Pred_taken/Pred_addr in
//            Resolve_valid/Resolve_addr/Resolve_taken/Resolve_target      in
//            Full, Flush_out, Redirect_addr, Branch_count,
//            Mispredict_count                                            out
// ----------------------------------------------------------------------------
module branch_verify_queue
  import branch_verify_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  branch_verify_queue_if.slave bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  bvq_entry_t wr_entry;
  bvq_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fetch_push;

  logic        exp_taken;
  logic        tgt_mismatch;
  logic        mispredict;
  logic [31:0] redirect;

  logic             flush_q,       flush_d;
  logic [31:0]      redirect_q,    redirect_d;
  logic [CNT_W-1:0] branch_cnt_q,  branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  assign fetch_push         = bus.Fetch_valid & bus.Fetch_is_branch;
  assign wr_entry.addr       = bus.Fetch_addr;
  assign wr_entry.pred_taken = bus.Pred_taken;
  assign wr_entry.pred_addr  = bus.Pred_addr;

  // Every resolve pops the head; a mispredict clears instead, which also
  // discards any push arriving in the same cycle.
  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .push_i     (fetch_push),
    .pop_i      (bus.Resolve_valid),
    .clear_i    (mispredict),
    .wr_entry_i (wr_entry),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // With no matching head entry the fetch stage fell through, i.e. it
  // effectively predicted not-taken. An address mismatch on its own is
  // therefore only a mispredict if the branch was actually taken.
  always_comb begin
    exp_taken = 1'b0;
    if (!fifo_empty && (head.addr == bus.Resolve_addr))
      exp_taken = head.pred_taken;
  end

  assign tgt_mismatch = bus.Resolve_taken & exp_taken
                      & (bus.Resolve_target != head.pred_addr);
  assign mispredict   = bus.Resolve_valid
                      & ((bus.Resolve_taken != exp_taken) | tgt_mismatch);

  // Not-taken successor wraps modulo 2^32.
  assign redirect = bus.Resolve_taken ? bus.Resolve_target
                                      : bus.Resolve_addr + BVQ_FALLTHRU;

  always_comb begin
    flush_d       = mispredict;
    redirect_d    = redirect_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (mispredict) begin
      redirect_d    = redirect;
      mispred_cnt_d = sat_inc(mispred_cnt_q);
    end
    if (bus.Resolve_valid) branch_cnt_d = sat_inc(branch_cnt_q);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.Full             = fifo_full;
  assign bus.Flush_out        = flush_q;
  assign bus.Redirect_addr    = redirect_q;
  assign bus.Branch_count     = branch_cnt_q;
  assign bus.Mispredict_count = mispred_cnt_q;

endmodule : branch_verify_queue

// File: doc/branch_verify_queue.md
# branch_verify_queue

Tracks every branch prediction from fetch until the branch resolves in MEM, then checks the prediction against the real outcome. Sits directly downstream of the hybrid predictor:
- **Input from fetch:** the predictor's `Taken`/`Taken_addr` for each fetched branch.
- **Input from MEM:** the actual branch outcome.
- **Output:** a one-cycle `Flush_out` pulse and a corrected fetch address (`Redirect_addr`) on a misprediction, plus running prediction statistics.

## Interface
Parameters:
- DEPTH, 4, maximum in-flight predicted branches; power of two, at least 2
- CNT_W, 32, width of the statistics counters

Ports:
- CLK  in  1  clock
- RESET  in  1  reset; asynchronous, active-low
- Fetch_valid  in  1  fetch stage presents an instruction this cycle
- Fetch_is_branch  in  1  that instruction is a branch or jump
- Fetch_addr  in  32  PC of that instruction
- Pred_taken  in  1  predictor's taken decision for Fetch_addr
- Pred_addr  in  32  predictor's target for Fetch_addr
- Resolve_valid  in  1  MEM holds a resolved branch this cycle
- Resolve_addr  in  32  PC of the resolved branch
- Resolve_taken  in  1  actual direction
- Resolve_target  in  32  actual target when taken
- Full  out  1  queue holds DEPTH entries; fetch must stall branches
- Flush_out  out  1  misprediction pulse to fetch and the predictor FLUSH input
- Redirect_addr  out  32  correct next fetch PC, valid while Flush_out=1
- Branch_count  out  CNT_W  number of resolved branches
- Mispredict_count  out  CNT_W  number of mispredictions

## Operation
- **Queue:** a circular FIFO of {addr, pred_taken, pred_addr} with read/write pointers of log2(DEPTH) bits that wrap, and a count of log2(DEPTH)+1 bits.
- **Push:** when Fetch_valid & Fetch_is_branch & !Full. A push while Full is dropped with no error; fetch guarantees it stalls instead.
- **Pop:** every Resolve_valid pops the head.
- **Comparison against the head entry** (the "expected" prediction):
  - With an empty queue, or when head addr ≠ Resolve_addr, the expected prediction is not-taken.
  - It is a mispredict if Resolve_taken ≠ expected pred_taken.
  - It is also a mispredict if both are taken and Resolve_target ≠ pred_addr.
  - A head addr mismatch alone does not count as a mispredict.
- **Redirect:**
  - If Resolve_taken=1, Redirect_addr = Resolve_target.
  - Otherwise Redirect_addr = Resolve_addr + 8, skipping the delay slot; the addition wraps modulo 2^32.
- **On mispredict:** the entire queue is cleared (pointers and count set to 0). All younger entries are wrong-path.
- **Simultaneous push and pop:**
  - Without a mispredict, both take effect and the count is unchanged.
  - With a mispredict, the clear wins and the push is discarded.
- **Counters:** Branch_count increments on each Resolve_valid. Mispredict_count increments on each mispredict. Both saturate at all-ones.
- **Reset:** asynchronous. All outputs, pointers, counters and the count go to 0. Assertion mid-operation discards all entries immediately.

## Timing
- The queue state is a register array. Full is decoded from the count register.
- Flush_out and Redirect_addr are registered and appear the cycle after Resolve_valid.
- Flush_out is high for exactly one cycle per mispredict and is 0 otherwise.
- Redirect_addr holds its last value while Flush_out is low.
- The queue clear takes effect in the same edge that raises Flush_out.
- The cycle Flush_out is high, fetch is being redirected. A push in that cycle is accepted normally, since it is the first correct-path instruction.
- Back-to-back Resolve_valid on consecutive cycles is supported. Each is checked against the queue as updated by the previous edge.

## Structure
- The shared package holds:
  - the entry struct {addr[31:0], pred_taken, pred_addr[31:0]}
  - the delay-slot fall-through constant 32'd8
- One sub-module, pred_fifo, is the natural split: a parameterised circular buffer with push/pop/clear/full/empty and head-entry output.
- Compare, redirect and counter logic stay in the top level.

## Test plan
- **Correct prediction:** push {0x100, taken, 0x200}, then resolve 0x100 taken→0x200. Expect no flush, Branch_count=1, Mispredict_count=0, and an empty queue.
- **Direction mispredict:** push {0x100, not-taken}, push {0x110, taken, 0x300}, then resolve 0x100 taken→0x400. Expect the next cycle Flush_out=1, Redirect_addr=0x400, queue empty, Mispredict_count=1.
- **Target mispredict and fall-through:**
  - push {0x100, taken, 0x200}, resolve 0x100 taken→0x240. Expect a flush to 0x240.
  - push {0x120, taken, 0x200}, resolve 0x120 not-taken. Expect a flush to 0x128.
- **Full/wrap:** push 4 entries. Expect Full=1 and a 5th push dropped. Then pop 4 correct resolves and push 4 more. Expect the pointers to wrap with no flush.
- **Simultaneous events and reset:**
  - Push during a mispredicting resolve. Expect the queue empty afterwards.
  - Assert RESET mid-queue with 3 entries. Expect all outputs and counters 0 immediately.
  - A resolve of 0xFFFFFFFC not-taken on an empty queue. Expect no flush (empty queue means expected not-taken, which matches).
  - A taken resolve on an empty queue. Expect a flush.
